// File: rtl/axi_beat_scoreboard.sv
// ---------------------------------------------------------------------------
// axi_beat_scoreboard
//
// Passive AXI4 beat scoreboard. Snoops the AW/W/AR/R channels, stores
// lane-masked write beats in an in-order FIFO and checks each read beat
// against the FIFO head. No AXI signal is driven.
//
// Optional feature macro: SCB_ADDR_CHECK_EN
//   defined     : each FIFO entry also keeps the aligned beat address; every
//                 read pop compares it with the read beat address and pulses
//                 addr_mismatch_o on inequality.
//   not defined : no address storage, addr_mismatch_o tied to 0.
//
// Ports
//   sys_clk, rst_n       clock; rst_n is asynchronous and ACTIVE-HIGH
//   clear_i              synchronous clear of FIFO, trackers, counters, flags
//   aw_* / w_*           write address / data channel (snooped)
//   ar_* / r_*           read address / data channel (snooped)
//   mismatch_o           1-cycle pulse, data mismatch on the previous R beat
//   err_sticky_o         any error seen since reset/clear
//   overflow_o           sticky, write beat dropped on a full FIFO
//   underflow_o          sticky, read beat seen with an empty FIFO
//   proto_err_o          sticky, burst protocol violation
//   addr_mismatch_o      1-cycle pulse, address mismatch (feature macro)
//   fill_o               FIFO occupancy
//   wr_beats_o/rd_beats_o/err_cnt_o  saturating counters
//
// Handshake semantics: a transfer happens on a channel exactly when its
// valid and ready are both 1 at a rising edge of sys_clk; nothing else about
// valid or ready is interpreted.
// ---------------------------------------------------------------------------
module axi_beat_scoreboard #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 128,
  parameter int Depth     = 16,
  parameter int CntWidth  = 16
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       aw_valid,
  input  logic                       aw_ready,
  input  logic [AddrWidth-1:0]       aw_addr,
  input  logic [7:0]                 aw_len,
  input  logic [2:0]                 aw_size,
  input  logic                       w_valid,
  input  logic                       w_ready,
  input  logic [DataWidth-1:0]       w_data,
  input  logic [DataWidth/8-1:0]     w_strb,
  input  logic                       w_last,
  input  logic                       ar_valid,
  input  logic                       ar_ready,
  input  logic [AddrWidth-1:0]       ar_addr,
  input  logic [7:0]                 ar_len,
  input  logic [2:0]                 ar_size,
  input  logic                       r_valid,
  input  logic                       r_ready,
  input  logic [DataWidth-1:0]       r_data,
  input  logic                       r_last,
  output logic                       mismatch_o,
  output logic                       err_sticky_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic                       proto_err_o,
  output logic                       addr_mismatch_o,
  output logic [$clog2(Depth):0]     fill_o,
  output logic [CntWidth-1:0]        wr_beats_o,
  output logic [CntWidth-1:0]        rd_beats_o,
  output logic [CntWidth-1:0]        err_cnt_o
);

  localparam int NB = DataWidth / 8;
  localparam int LB = $clog2(NB);
  localparam int PW = $clog2(Depth);
  localparam logic [PW:0] FillFull = (PW+1)'(Depth);

  typedef enum logic {TRK_IDLE = 1'b0, TRK_ACTIVE = 1'b1} trk_e;

  // Lanes off .. al+2^size-1 where al is off aligned down to the beat size.
  // For later beats off is already aligned, so one formula covers both cases.
  function automatic logic [NB-1:0] lane_mask(input logic [LB-1:0] off,
                                              input logic [2:0]    size);
    logic [7:0] o;
    logic [7:0] al;
    logic [8:0] hi_ex;
    logic [NB-1:0] m;
    o     = 8'(off);
    al    = (o >> size) << size;
    hi_ex = {1'b0, al} + (9'd1 << size);
    for (int i = 0; i < NB; i++) begin
      m[i] = (9'(i) >= {1'b0, o}) && (9'(i) < hi_ex);
    end
    return m;
  endfunction

  function automatic logic [DataWidth-1:0] lanes_to_bits(input logic [NB-1:0] l);
    logic [DataWidth-1:0] b;
    for (int i = 0; i < NB; i++) begin
      b[i*8 +: 8] = {8{l[i]}};
    end
    return b;
  endfunction

  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] c,
                                                  input logic [1:0]          inc);
    logic [CntWidth:0] s;
    s = {1'b0, c} + (CntWidth+1)'(inc);
    return s[CntWidth] ? {CntWidth{1'b1}} : s[CntWidth-1:0];
  endfunction

  // ---------------- burst trackers ----------------
  trk_e                 w_st_q, r_st_q;
  logic [AddrWidth-1:0] w_addr_q, r_addr_q;
  logic [2:0]           w_size_q, r_size_q;
  logic [8:0]           w_cnt_q, r_cnt_q;   // beats remaining, len+1 at start

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic w_beat, r_beat, w_final, r_final;
  logic [AddrWidth-1:0] w_aligned, r_aligned, w_next, r_next;

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid  && w_ready;
  assign ar_hs = ar_valid && ar_ready;
  assign r_hs  = r_valid  && r_ready;

  assign w_beat  = w_hs && (w_st_q == TRK_ACTIVE);
  assign r_beat  = r_hs && (r_st_q == TRK_ACTIVE);
  assign w_final = (w_cnt_q == 9'd1);
  assign r_final = (r_cnt_q == 9'd1);

  // Align-then-step gives the first-beat rule; later beats are already
  // aligned so the same expression is a plain increment for them.
  assign w_aligned = (w_addr_q >> w_size_q) << w_size_q;
  assign r_aligned = (r_addr_q >> r_size_q) << r_size_q;
  assign w_next    = w_aligned + (AddrWidth'(1) << w_size_q);
  assign r_next    = r_aligned + (AddrWidth'(1) << r_size_q);

  always_ff @(posedge sys_clk or posedge rst_n) begin
    if (rst_n || clear_i) begin
      w_st_q <= TRK_IDLE; w_addr_q <= '0; w_size_q <= '0; w_cnt_q <= '0;
    end else begin
      case (w_st_q)
        TRK_IDLE: if (aw_hs) begin
          w_st_q   <= TRK_ACTIVE;
          w_addr_q <= aw_addr;
          w_size_q <= aw_size;
          w_cnt_q  <= {1'b0, aw_len} + 9'd1;
        end
        TRK_ACTIVE: if (w_hs) begin
          if (w_final) begin
            w_st_q <= TRK_IDLE;
          end else begin
            w_addr_q <= w_next;
            w_cnt_q  <= w_cnt_q - 9'd1;
          end
        end
        default: w_st_q <= TRK_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst_n) begin
    if (rst_n || clear_i) begin
      r_st_q <= TRK_IDLE; r_addr_q <= '0; r_size_q <= '0; r_cnt_q <= '0;
    end else begin
      case (r_st_q)
        TRK_IDLE: if (ar_hs) begin
          r_st_q   <= TRK_ACTIVE;
          r_addr_q <= ar_addr;
          r_size_q <= ar_size;
          r_cnt_q  <= {1'b0, ar_len} + 9'd1;
        end
        TRK_ACTIVE: if (r_hs) begin
          if (r_final) begin
            r_st_q <= TRK_IDLE;
          end else begin
            r_addr_q <= r_next;
            r_cnt_q  <= r_cnt_q - 9'd1;
          end
        end
        default: r_st_q <= TRK_IDLE;
      endcase
    end
  end

  // ---------------- expected-beat FIFO ----------------
  logic [DataWidth-1:0] mem_q [Depth];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          fill_q, fill_d;

  logic [DataWidth-1:0] w_exp, r_got;
  logic push, pop, ovf_ev, udf_ev, proto_ev, mis_ev, amis_ev;
  logic [1:0] err_inc;

  assign w_exp = w_data & lanes_to_bits(lane_mask(w_addr_q[LB-1:0], w_size_q) & w_strb);
  assign r_got = r_data & lanes_to_bits(lane_mask(r_addr_q[LB-1:0], r_size_q));

  // A pop frees the slot in the same cycle, so a full FIFO still accepts
  // a push paired with a pop. An empty FIFO cannot pop (no bypass).
  assign pop    = r_beat && (fill_q != '0);
  assign push   = w_beat && ((fill_q != FillFull) || pop);
  assign ovf_ev = w_beat && !push;
  assign udf_ev = r_beat && (fill_q == '0);
  assign mis_ev = pop && (r_got != mem_q[rd_ptr_q]);

  // Data beats with no open burst are flagged on both sides and not processed.
  assign proto_ev = (aw_hs && (w_st_q == TRK_ACTIVE)) ||
                    (ar_hs && (r_st_q == TRK_ACTIVE)) ||
                    (w_hs  && (w_st_q == TRK_IDLE))   ||
                    (r_hs  && (r_st_q == TRK_IDLE))   ||
                    (w_beat && (w_last != w_final))   ||
                    (r_beat && (r_last != r_final));

`ifdef SCB_ADDR_CHECK_EN
  logic [AddrWidth-1:0] amem_q [Depth];
  assign amis_ev = pop && (r_aligned != amem_q[rd_ptr_q]);

  always_ff @(posedge sys_clk) begin
    if (push && !clear_i) amem_q[wr_ptr_q] <= w_aligned;
  end
`else
  assign amis_ev = 1'b0;
`endif

  assign err_inc = {1'b0, ovf_ev} + {1'b0, mis_ev} + {1'b0, amis_ev};

  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push && !clear_i) mem_q[wr_ptr_q] <= w_exp;
  end

  always_ff @(posedge sys_clk or posedge rst_n) begin
    if (rst_n || clear_i) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fill_q          <= '0;
      mismatch_o      <= 1'b0;
      addr_mismatch_o <= 1'b0;
      err_sticky_o    <= 1'b0;
      overflow_o      <= 1'b0;
      underflow_o     <= 1'b0;
      proto_err_o     <= 1'b0;
      wr_beats_o      <= '0;
      rd_beats_o      <= '0;
      err_cnt_o       <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      fill_q          <= fill_d;
      mismatch_o      <= mis_ev;
      addr_mismatch_o <= amis_ev;
      if (ovf_ev)   overflow_o  <= 1'b1;
      if (udf_ev)   underflow_o <= 1'b1;
      if (proto_ev) proto_err_o <= 1'b1;
      if (ovf_ev || udf_ev || proto_ev || mis_ev || amis_ev) err_sticky_o <= 1'b1;
      wr_beats_o <= sat_add(wr_beats_o, {1'b0, w_hs});
      rd_beats_o <= sat_add(rd_beats_o, {1'b0, r_hs});
      err_cnt_o  <= sat_add(err_cnt_o, err_inc);
    end
  end

  assign fill_o = fill_q;

endmodule
